// File: rtl/aurora_user_pkg.sv
// Definitions shared by the Aurora 64B66B user-interface generator and checker:
// frame geometry, the full byte-enable value and the checker state encoding.
package aurora_user_pkg;

   localparam int          C_FRAME_LEN  = 100;
   localparam logic [7:0]  C_TKEEP_FULL = 8'hff;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// A clear has priority over an increment in the same cycle.
module sat_counter #(
   parameter int P_W = 32
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_inc,
   input  logic           i_clr,
   output logic [P_W-1:0] o_cnt
);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_cnt <= '0;
      end else if (i_clr) begin
         o_cnt <= '0;
      end else if (i_inc && (o_cnt != '1)) begin
         // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
         o_cnt <= o_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/user_data_chk.sv
// Aurora RX user-data checker: verifies fixed-length, counting-pattern frames with
// full tkeep, and reports error pulses, saturating statistics and link qualification.
module user_data_chk
   import aurora_user_pkg::*;
#(
   parameter int P_FRAME_LEN   = C_FRAME_LEN,
   parameter int P_GOOD_FRAMES = 4,
   parameter int P_CNT_W       = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [63:0]        s_axi_rx_tdata,
   input  logic [7:0]         s_axi_rx_tkeep,
   input  logic               s_axi_rx_tlast,
   input  logic               s_axi_rx_tvalid,
   input  logic               i_clear,
   output logic               o_frame_done,
   output logic               o_frame_good,
   output logic               o_data_err,
   output logic               o_keep_err,
   output logic               o_len_err,
   output logic [P_CNT_W-1:0] o_frame_cnt,
   output logic [P_CNT_W-1:0] o_err_cnt,
   output logic               o_link_ok,
   output logic               o_busy
);

   localparam int               C_GOOD_W   = $clog2(P_GOOD_FRAMES + 1);
   localparam logic [C_GOOD_W-1:0] C_GOOD_MAX = C_GOOD_W'(P_GOOD_FRAMES);
   localparam logic [C_GOOD_W-1:0] C_GOOD_PRE = C_GOOD_W'(P_GOOD_FRAMES - 1);
   localparam logic [15:0]      C_LAST_IDX = 16'(P_FRAME_LEN - 1);

   state_t              r_state;
   logic [15:0]         r_idx;
   logic [63:0]         r_exp;
   logic                r_sticky;
   logic [C_GOOD_W-1:0] r_good;

   logic w_check, w_last_idx, w_data_err, w_keep_err, w_len_err;
   logic w_done, w_good;

   // Beats in ST_DRAIN are only watched for tlast; everything else is checked.
   assign w_check    = s_axi_rx_tvalid && (r_state != ST_DRAIN);
   assign w_last_idx = (r_idx == C_LAST_IDX);
   assign w_data_err = w_check && (s_axi_rx_tdata != r_exp);
   assign w_keep_err = w_check && (s_axi_rx_tkeep != C_TKEEP_FULL);
   assign w_len_err  = w_check && (s_axi_rx_tlast != w_last_idx);
   assign w_done     = s_axi_rx_tvalid && s_axi_rx_tlast;
   assign w_good     = !(r_sticky || w_data_err || w_keep_err || w_len_err ||
                         (r_state == ST_DRAIN));

   assign o_busy = (r_state != ST_IDLE);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_idx        <= '0;
         r_exp        <= '0;
         r_sticky     <= 1'b0;
         r_good       <= '0;
         o_frame_done <= 1'b0;
         o_frame_good <= 1'b0;
         o_data_err   <= 1'b0;
         o_keep_err   <= 1'b0;
         o_len_err    <= 1'b0;
         o_link_ok    <= 1'b0;
      end else begin
         o_data_err   <= w_data_err;
         o_keep_err   <= w_keep_err;
         o_len_err    <= w_len_err;
         o_frame_done <= w_done;
         o_frame_good <= w_done && w_good;

         if (w_done)
            r_sticky <= 1'b0;
         else if (w_data_err || w_keep_err || w_len_err)
            r_sticky <= 1'b1;

         if (s_axi_rx_tvalid) begin
            case (r_state)
               ST_IDLE, ST_RECV: begin
                  if (s_axi_rx_tlast || w_last_idx) begin
                     r_state <= s_axi_rx_tlast ? ST_IDLE : ST_DRAIN;
                     r_idx   <= '0;
                     r_exp   <= '0;
                  end else begin
                     r_state <= ST_RECV;
                     r_idx   <= r_idx + 16'd1;
                     r_exp   <= r_exp + 64'd1;
                  end
               end
               ST_DRAIN: if (s_axi_rx_tlast) r_state <= ST_IDLE;
               default:  r_state <= ST_IDLE;
            endcase
         end

         // Clear overrides a frame completion landing in the same cycle.
         if (i_clear) begin
            r_good    <= '0;
            o_link_ok <= 1'b0;
         end else if (w_done) begin
            if (w_good) begin
               if (r_good != C_GOOD_MAX) r_good <= r_good + 1'b1;
               if (r_good >= C_GOOD_PRE) o_link_ok <= 1'b1;
            end else begin
               r_good    <= '0;
               o_link_ok <= 1'b0;
            end
         end
      end
   end

   sat_counter #(.P_W(P_CNT_W)) u_frame_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (w_done && w_good),
      .i_clr (i_clear),
      .o_cnt (o_frame_cnt)
   );

   sat_counter #(.P_W(P_CNT_W)) u_err_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (w_done && !w_good),
      .i_clr (i_clear),
      .o_cnt (o_err_cnt)
   );

endmodule

// File: tb/tb_user_data_chk.sv
// Directed bench for user_data_chk: a table of whole-frame vectors with cumulative
// expected statistics, plus hand sequences for reset, clear and counter saturation.
module tb_user_data_chk;

   localparam int W = 32;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [63:0]   tdata;
   logic [7:0]    tkeep;
   logic          tlast, tvalid, i_clear;
   logic          o_frame_done, o_frame_good, o_data_err, o_keep_err, o_len_err;
   logic [W-1:0]  o_frame_cnt, o_err_cnt;
   logic          o_link_ok, o_busy;

   logic          s_inc, s_clr;
   logic [2:0]    s_cnt;

   always #5 i_clk = ~i_clk;

   user_data_chk #(.P_FRAME_LEN(100), .P_GOOD_FRAMES(4), .P_CNT_W(W)) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .s_axi_rx_tdata  (tdata),
      .s_axi_rx_tkeep  (tkeep),
      .s_axi_rx_tlast  (tlast),
      .s_axi_rx_tvalid (tvalid),
      .i_clear         (i_clear),
      .o_frame_done    (o_frame_done),
      .o_frame_good    (o_frame_good),
      .o_data_err      (o_data_err),
      .o_keep_err      (o_keep_err),
      .o_len_err       (o_len_err),
      .o_frame_cnt     (o_frame_cnt),
      .o_err_cnt       (o_err_cnt),
      .o_link_ok       (o_link_ok),
      .o_busy          (o_busy)
   );

   sat_counter #(.P_W(3)) u_sat (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (s_inc),
      .i_clr (s_clr),
      .o_cnt (s_cnt)
   );

   typedef struct {
      string       name;
      int          n_beats;
      bit          has_last;
      int          dbeat;
      logic [63:0] dval;
      int          kbeat;
      logic [7:0]  kval;
      int          e_data;
      int          e_keep;
      int          e_len;
      int          e_at;
      bit          e_good;
      int          e_fc;
      int          e_ec;
      bit          e_link;
   } vec_t;

   vec_t tbl[$];

   int n_vec  = 0;
   int n_miss = 0;

   int          seen_data, seen_keep, seen_len, seen_done;
   int          data_at, keep_at, len_at, done_at;
   logic        done_good, done_link, done_busy;
   logic [W-1:0] done_fc, done_ec;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      seen_data = 0; seen_keep = 0; seen_len = 0; seen_done = 0;
      data_at = -2; keep_at = -2; len_at = -2; done_at = -2;
      done_good = 1'bx; done_link = 1'bx; done_busy = 1'bx;
      done_fc = 'x; done_ec = 'x;
   endtask

   // Drive one cycle at the falling edge, then sample the registered response
   // at the next falling edge; beat = -1 marks a non-valid cycle.
   task automatic cycle(input logic v, input logic [63:0] d, input logic [7:0] k,
                        input logic l, input logic clr, input int beat);
      tvalid = v; tdata = d; tkeep = k; tlast = l; i_clear = clr;
      @(posedge i_clk);
      @(negedge i_clk);
      if (o_data_err) begin seen_data++; data_at = beat; end
      if (o_keep_err) begin seen_keep++; keep_at = beat; end
      if (o_len_err)  begin seen_len++;  len_at  = beat; end
      if (o_frame_done) begin
         seen_done++;
         done_at   = beat;
         done_good = o_frame_good;
         done_fc   = o_frame_cnt;
         done_ec   = o_err_cnt;
         done_link = o_link_ok;
         done_busy = o_busy;
      end
   endtask

   task automatic send_frame(input int n, input bit has_last, input int dbeat,
                             input logic [63:0] dval, input int kbeat,
                             input logic [7:0] kval, input bit clr_last);
      for (int i = 0; i < n; i++) begin
         logic [63:0] d;
         logic [7:0]  k;
         logic        l;
         if ($urandom_range(0, 3) == 0)
            cycle(1'b0, {$urandom, $urandom}, 8'h00, 1'b1, 1'b0, -1);
         d = (i == dbeat) ? dval : 64'(i);
         k = (i == kbeat) ? kval : 8'hff;
         l = has_last && (i == n - 1);
         cycle(1'b1, d, k, l, clr_last && (i == n - 1), i);
      end
      cycle(1'b0, 64'd0, 8'h00, 1'b0, 1'b0, -1);
   endtask

   initial begin
      i_rst = 1'b1; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; i_clear = 1'b0;
      s_inc = 1'b0; s_clr = 1'b0;

      //          name      n  last dbeat dval      kbeat kval   d k l at  good fc ec link
      tbl.push_back('{"clean0",  100, 1, -1, 64'h0,  -1, 8'hff, 0, 0, 0, -1, 1,  1, 0, 0});
      tbl.push_back('{"clean1",  100, 1, -1, 64'h0,  -1, 8'hff, 0, 0, 0, -1, 1,  2, 0, 0});
      tbl.push_back('{"clean2",  100, 1, -1, 64'h0,  -1, 8'hff, 0, 0, 0, -1, 1,  3, 0, 0});
      tbl.push_back('{"clean3",  100, 1, -1, 64'h0,  -1, 8'hff, 0, 0, 0, -1, 1,  4, 0, 1});
      tbl.push_back('{"clean4",  100, 1, -1, 64'h0,  -1, 8'hff, 0, 0, 0, -1, 1,  5, 0, 1});
      tbl.push_back('{"data37",  100, 1, 37, 64'h55, -1, 8'hff, 1, 0, 0, 37, 0,  5, 1, 0});
      tbl.push_back('{"clean5",  100, 1, -1, 64'h0,  -1, 8'hff, 0, 0, 0, -1, 1,  6, 1, 0});
      tbl.push_back('{"clean6",  100, 1, -1, 64'h0,  -1, 8'hff, 0, 0, 0, -1, 1,  7, 1, 0});
      tbl.push_back('{"clean7",  100, 1, -1, 64'h0,  -1, 8'hff, 0, 0, 0, -1, 1,  8, 1, 0});
      tbl.push_back('{"clean8",  100, 1, -1, 64'h0,  -1, 8'hff, 0, 0, 0, -1, 1,  9, 1, 1});
      tbl.push_back('{"short50",  50, 1, -1, 64'h0,  -1, 8'hff, 0, 0, 1, 49, 0,  9, 2, 0});
      tbl.push_back('{"clean9",  100, 1, -1, 64'h0,  -1, 8'hff, 0, 0, 0, -1, 1, 10, 2, 0});
      tbl.push_back('{"long121", 121, 1, 110, 64'h55, -1, 8'hff, 0, 0, 1, 99, 0, 10, 3, 0});
      tbl.push_back('{"clean10", 100, 1, -1, 64'h0,  -1, 8'hff, 0, 0, 0, -1, 1, 11, 3, 0});
      tbl.push_back('{"keep10",  100, 1, 10, 64'hdead, 10, 8'h0f, 1, 1, 0, 10, 0, 11, 4, 0});
      tbl.push_back('{"clean11", 100, 1, -1, 64'h0,  -1, 8'hff, 0, 0, 0, -1, 1, 12, 4, 0});
      tbl.push_back('{"onebeat",   1, 1, -1, 64'h0,  -1, 8'hff, 0, 0, 1,  0, 0, 12, 5, 0});

      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("reset frame_done", o_frame_done, 0);
      check("reset frame_good", o_frame_good, 0);
      check("reset errs", {o_data_err, o_keep_err, o_len_err}, 0);
      check("reset frame_cnt", o_frame_cnt, 0);
      check("reset err_cnt", o_err_cnt, 0);
      check("reset link_ok", o_link_ok, 0);
      check("reset busy", o_busy, 0);
      i_rst = 1'b0;

      for (int v = 0; v < tbl.size(); v++) begin
         clear_mon();
         send_frame(tbl[v].n_beats, tbl[v].has_last, tbl[v].dbeat, tbl[v].dval,
                    tbl[v].kbeat, tbl[v].kval, 1'b0);
         check({tbl[v].name, " data_err pulses"}, seen_data, tbl[v].e_data);
         check({tbl[v].name, " keep_err pulses"}, seen_keep, tbl[v].e_keep);
         check({tbl[v].name, " len_err pulses"},  seen_len,  tbl[v].e_len);
         if (tbl[v].e_data > 0) check({tbl[v].name, " data_err beat"}, data_at, tbl[v].e_at);
         if (tbl[v].e_keep > 0) check({tbl[v].name, " keep_err beat"}, keep_at, tbl[v].e_at);
         if (tbl[v].e_len > 0)  check({tbl[v].name, " len_err beat"},  len_at,  tbl[v].e_at);
         check({tbl[v].name, " done pulses"}, seen_done, 1);
         check({tbl[v].name, " done beat"},   done_at, tbl[v].n_beats - 1);
         check({tbl[v].name, " frame_good"},  done_good, tbl[v].e_good);
         check({tbl[v].name, " frame_cnt"},   done_fc, tbl[v].e_fc);
         check({tbl[v].name, " err_cnt"},     done_ec, tbl[v].e_ec);
         check({tbl[v].name, " link_ok"},     done_link, tbl[v].e_link);
         check({tbl[v].name, " busy at done"}, done_busy, 0);
      end

      // Reset in the middle of a frame: the partial frame leaves no trace.
      clear_mon();
      for (int i = 0; i < 60; i++) cycle(1'b1, 64'(i), 8'hff, 1'b0, 1'b0, i);
      check("midframe busy", o_busy, 1);
      tvalid = 1'b0;
      i_rst  = 1'b1;
      #1;
      check("async reset busy", o_busy, 0);
      check("async reset frame_cnt", o_frame_cnt, 0);
      check("async reset err_cnt", o_err_cnt, 0);
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      clear_mon();
      send_frame(100, 1'b1, -1, 64'h0, -1, 8'hff, 1'b0);
      check("post-reset errors", seen_data + seen_keep + seen_len, 0);
      check("post-reset frame_good", done_good, 1);
      check("post-reset frame_cnt", done_fc, 1);
      check("post-reset err_cnt", done_ec, 0);

      // Clear landing on the same beat that closes a bad frame.
      clear_mon();
      send_frame(10, 1'b1, -1, 64'h0, -1, 8'hff, 1'b1);
      check("clear+bad len_err", seen_len, 1);
      check("clear+bad done", seen_done, 1);
      check("clear+bad frame_good", done_good, 0);
      check("clear+bad err_cnt", done_ec, 0);
      check("clear+bad frame_cnt", done_fc, 0);
      check("clear+bad link_ok", done_link, 0);

      // Saturation of the statistics counter at a narrow width.
      s_inc = 1'b1;
      repeat (7) @(posedge i_clk);
      @(negedge i_clk);
      check("sat count 7", s_cnt, 7);
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      check("sat hold 7", s_cnt, 7);
      s_clr = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      check("sat clear beats inc", s_cnt, 0);
      s_inc = 1'b0; s_clr = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/user_data_chk.md
Name: user_data_chk

Overview:
- Receive-side companion to the TX user data generator on the Aurora 64B66B user interface.
- Consumes the core's AXI4-Stream RX output and checks every frame against the generator's pattern:
  - fixed-length frames;
  - data counting 0,1,2,… from the first beat;
  - full tkeep on every beat.
- Reports per-event error pulses, saturating statistics and a link-qualification flag for board bring-up and ILA observation.

Parameters:
P_FRAME_LEN, 100, beats per frame; tlast required on beat index P_FRAME_LEN-1
P_GOOD_FRAMES, 4, consecutive good frames needed to assert o_link_ok
P_CNT_W, 32, width of statistics counters

Ports:
i_clk  in  1  user clock, all logic on rising edge
i_rst  in  1  asynchronous active-high reset
s_axi_rx_tdata  in  64  RX beat data
s_axi_rx_tkeep  in  8  RX byte enables
s_axi_rx_tlast  in  1  RX end of frame
s_axi_rx_tvalid  in  1  RX beat valid; no tready, every valid beat is consumed
i_clear  in  1  synchronous clear of statistics counters and o_link_ok
o_frame_done  out  1  one-cycle pulse: a frame has finished checking
o_frame_good  out  1  qualifies o_frame_done: 1 = frame had no error
o_data_err  out  1  one-cycle pulse: data mismatch on a beat
o_keep_err  out  1  one-cycle pulse: tkeep != 8'hff on a beat
o_len_err  out  1  one-cycle pulse: short or long frame
o_frame_cnt  out  P_CNT_W  good frames received, saturating
o_err_cnt  out  P_CNT_W  bad frames received, saturating
o_link_ok  out  1  level: P_GOOD_FRAMES consecutive good frames seen
o_busy  out  1  level: inside a frame (state != ST_IDLE)

Behaviour:
- Reset (async, i_rst=1): all outputs 0, state ST_IDLE, beat index 0, expected data 0, frame-error sticky 0, consecutive-good count 0.
- Beat = cycle with s_axi_rx_tvalid=1; non-valid cycles change nothing.
- State machine:
  - ST_IDLE: a beat enters ST_RECV, checked as index 0 against expected data 0. A beat with tlast in ST_IDLE is a 1-beat frame: short unless P_FRAME_LEN=1; frame completes and state stays ST_IDLE.
  - ST_RECV: each beat compares tdata with the expected value (64-bit compare, expected increments by 1 per beat, wraps modulo 2^64) and tkeep with 8'hff; the beat index increments.
    - tlast with index < P_FRAME_LEN-1: short frame, o_len_err, frame done, go to ST_IDLE.
    - tlast at index P_FRAME_LEN-1: length OK, frame done, go to ST_IDLE.
    - No tlast at index P_FRAME_LEN-1: long frame, o_len_err, go to ST_DRAIN.
  - ST_DRAIN: beats are ignored (no data/keep checks, no further pulses) until a beat with tlast, which produces frame done (bad) and a return to ST_IDLE.
- Error pulses and o_frame_done/o_frame_good are registered: asserted the cycle after the offending or closing beat, for exactly 1 cycle.
- Several error types on one beat assert their pulses together.
- Frame-error sticky: set by any data, keep or length error in the frame; cleared when the frame completes.
- Frame completion:
  - good frame: o_frame_cnt+1 and consecutive-good+1; o_link_ok set when consecutive-good reaches P_GOOD_FRAMES (the counter saturates there);
  - bad frame: o_err_cnt+1, consecutive-good cleared, o_link_ok cleared.
- Counters saturate at all-ones; they never wrap.
- i_clear: next cycle, o_frame_cnt, o_err_cnt, consecutive-good and o_link_ok are 0. Clear wins over a simultaneous increment. Frame checking state is not affected.
- Reset mid-frame: the partial frame is discarded and not counted. The next beat is treated as beat 0 of a new frame.
- The beat index register is 16 bits; P_FRAME_LEN must be ≤ 65535.

Decomposition:
- Shared package (aurora_user_pkg): frame length constant (100, shared with the generator), tkeep full value 8'hff, and the state encoding ST_IDLE/ST_RECV/ST_DRAIN.
- One natural sub-module: sat_counter (width parameter, inc, clr, saturating), instantiated for o_frame_cnt and o_err_cnt.
- The checker FSM stays in the top.

Test Plan:
- 5 back-to-back clean frames, data 0..99, tlast on beat 99, tkeep ff, with random tvalid gaps -> 5 o_frame_done with o_frame_good=1, o_frame_cnt=5, o_err_cnt=0, o_link_ok rises 1 cycle after the 4th frame ends.
- Frame with beat 37 data = 64'h55 -> o_data_err 1 cycle after beat 37; frame ends bad; o_err_cnt=1; o_link_ok falls; next 4 clean frames restore it.
- tlast on beat 49 -> o_len_err and o_frame_done (good=0) 1 cycle later; an immediate clean frame is counted good, data expected from 0.
- No tlast at beat 99, tlast on beat 120 -> o_len_err once after beat 99; no pulses during drain; o_frame_done (good=0) after beat 120; next frame checks clean.
- tkeep=8'h0f on beat 10 together with wrong data -> o_keep_err and o_data_err in the same cycle; o_err_cnt +1 only.
- i_rst at beat 60 then a clean frame -> no count for the partial frame, o_frame_cnt=1. Separately, i_clear in the same cycle as a bad-frame completion -> o_err_cnt=0.
